// File: rtl/vector_serializer_if.sv
// Handshake bundle for vector_serializer: a parallel vector comes in on a
// valid/ready pair, and single elements go out on a valid/ready stream.
interface vector_serializer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LENGTH     = 16
);
  localparam int IDX_WIDTH = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  logic [DATA_WIDTH-1:0] in_vec [0:LENGTH-1];
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [IDX_WIDTH-1:0]  out_index;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;

  // Environment side: supplies vectors and consumes the element stream.
  modport master (
    output in_vec, in_valid, out_ready,
    input  in_ready, out_data, out_index, out_last, out_valid, busy
  );

  // Serializer side.
  modport slave (
    input  in_vec, in_valid, out_ready,
    output in_ready, out_data, out_index, out_last, out_valid, busy
  );
endinterface

// File: rtl/vector_serializer.sv
// Vector serializer: captures one LENGTH-element vector in parallel and
// streams it out one element per cycle in index order. Element contents are
// opaque bit patterns. A new vector can be taken in the same cycle the last
// element leaves, so back-to-back vectors stream without a bubble.
module vector_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int LENGTH     = 16
) (
  input  logic                clk,
  input  logic                reset,
  vector_serializer_if.slave  bus
);
  localparam int IDX_WIDTH = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(LENGTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic [DATA_WIDTH-1:0] buf_q [0:LENGTH-1];

  logic sending;
  logic at_last;

  assign sending = (state_q == SEND);
  assign at_last = (idx_q == LAST_IDX);

  // Stream outputs come straight from the held state; in_ready also looks at
  // out_ready so the final element's transfer can admit the next vector.
  assign bus.out_valid = sending;
  assign bus.busy      = sending;
  assign bus.out_index = idx_q;
  assign bus.out_last  = sending & at_last;
  assign bus.in_ready  = ~sending | (bus.out_ready & at_last);

  if (LENGTH == 1) begin : g_single
    assign bus.out_data = buf_q[0];
  end else begin : g_multi
    assign bus.out_data = buf_q[idx_q];
  end

  // Sequencer: capture a vector, step the index on each output transfer,
  // and either chain the next vector or return to IDLE after the last one.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      // NOTE: the buffer is a small register array (not a RAM), so it is
      // cleared on reset to make out_data read zero out of reset.
      for (int i = 0; i < LENGTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            buf_q   <= bus.in_vec;
            idx_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            if (!at_last) begin
              idx_q <= idx_q + 1'b1;
            end else if (bus.in_valid) begin
              buf_q <= bus.in_vec;
              idx_q <= '0;
            end else begin
              idx_q   <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vector_serializer.sv
// Testbench for vector_serializer: a LENGTH=4 and a LENGTH=1 instance are
// driven each cycle and compared against a queue-based reference model.
module tb_vector_serializer;
  localparam int DW = 16;
  localparam int L4 = 4;
  localparam int L1 = 1;

  typedef logic [DW-1:0] vec4_t [L4];

  typedef struct packed {
    logic          valid;
    logic          busy;
    logic          in_ready;
    logic          last;
    logic [7:0]    index;
    logic [DW-1:0] data;
  } obs_t;

  localparam obs_t RESET_OBS = '{valid: 1'b0, busy: 1'b0, in_ready: 1'b1,
                                 last: 1'b0, index: 8'd0, data: 16'h0000};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vector_serializer_if #(.DATA_WIDTH(DW), .LENGTH(L4)) bus4 ();
  vector_serializer_if #(.DATA_WIDTH(DW), .LENGTH(L1)) bus1 ();

  vector_serializer #(.DATA_WIDTH(DW), .LENGTH(L4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  vector_serializer #(.DATA_WIDTH(DW), .LENGTH(L1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a vector held by the block is the queue of elements not
  // yet delivered; the element shown when idle is element 0 of the last vector.
  logic [DW-1:0] q4[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] h4;
  logic [DW-1:0] h1;
  logic [DW-1:0] got4[$];
  logic [DW-1:0] want4[$];
  logic [DW-1:0] got1[$];
  logic [DW-1:0] want1[$];

  obs_t obs4, exp4, obs1, exp1;
  vec4_t zv = '{default: '0};

  function automatic obs_t model_out(int len, int n, logic [DW-1:0] front, bit ordy);
    obs_t e;
    e.valid    = (n != 0);
    e.busy     = (n != 0);
    e.in_ready = (n == 0) || (n == 1 && ordy);
    e.last     = (n == 1);
    e.index    = (n == 0) ? 8'd0 : 8'(len - n);
    e.data     = front;
    return e;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("valid=%b busy=%b in_ready=%b last=%b index=%0d data=%h",
                     o.valid, o.busy, o.in_ready, o.last, o.index, o.data);
  endfunction

  function automatic obs_t grab4();
    obs_t o;
    o.valid = bus4.out_valid; o.busy = bus4.busy; o.in_ready = bus4.in_ready;
    o.last  = bus4.out_last;  o.index = 8'(bus4.out_index); o.data = bus4.out_data;
    return o;
  endfunction

  function automatic obs_t grab1();
    obs_t o;
    o.valid = bus1.out_valid; o.busy = bus1.busy; o.in_ready = bus1.in_ready;
    o.last  = bus1.out_last;  o.index = 8'(bus1.out_index); o.data = bus1.out_data;
    return o;
  endfunction

  function automatic vec4_t rand_vec();
    vec4_t v;
    foreach (v[i]) v[i] = DW'($urandom);
    return v;
  endfunction

  task automatic model_reset();
    q4.delete(); q1.delete(); got4.delete(); want4.delete(); got1.delete(); want1.delete();
    h4 = '0; h1 = '0;
  endtask

  // One clock cycle: drive both instances at the falling edge, sample their
  // outputs shortly after, then advance the model to the next rising edge.
  task automatic step(input logic iv4, input vec4_t v4, input logic or4,
                      input logic iv1, input logic [DW-1:0] d1, input logic or1);
    int n;
    logic [DW-1:0] front;
    logic [DW-1:0] tmp;
    @(negedge clk);
    bus4.in_valid = iv4; bus4.in_vec = v4; bus4.out_ready = or4;
    bus1.in_valid = iv1; bus1.in_vec[0] = d1; bus1.out_ready = or1;
    #1;
    obs4 = grab4();
    obs1 = grab1();
    n = q4.size();
    front = h4;
    if (n != 0) front = q4[0];
    exp4 = model_out(L4, n, front, or4 === 1'b1);
    n = q1.size();
    front = h1;
    if (n != 0) front = q1[0];
    exp1 = model_out(L1, n, front, or1 === 1'b1);

    if (obs4.valid === 1'b1 && or4 === 1'b1) got4.push_back(obs4.data);
    if (obs1.valid === 1'b1 && or1 === 1'b1) got1.push_back(obs1.data);
    if (exp4.valid && or4 === 1'b1) tmp = q4.pop_front();
    if (exp1.valid && or1 === 1'b1) tmp = q1.pop_front();
    if (iv4 === 1'b1 && exp4.in_ready) begin
      foreach (v4[i]) begin
        q4.push_back(v4[i]);
        want4.push_back(v4[i]);
      end
      h4 = v4[0];
    end
    if (iv1 === 1'b1 && exp1.in_ready) begin
      q1.push_back(d1);
      want1.push_back(d1);
      h1 = d1;
    end
  endtask

  task automatic step4(input logic iv, input vec4_t v, input logic ordy);
    step(iv, v, ordy, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_vec = zv; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_vec[0] = '0; bus1.out_ready = 1'b0;
    #2;
    obs4 = grab4();
    obs1 = grab1();
    checks++;
    if (obs4 !== RESET_OBS) begin
      errors++; $display("FAIL reset_len4 got %s want %s", fmt(obs4), fmt(RESET_OBS));
    end
    checks++;
    if (obs1 !== RESET_OBS) begin
      errors++; $display("FAIL reset_len1 got %s want %s", fmt(obs1), fmt(RESET_OBS));
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step4(1'b0, zv, 1'b1);
    checks++;
    if (obs4 !== exp4) begin
      errors++; $display("FAIL reset_release got %s want %s", fmt(obs4), fmt(exp4));
    end
  endtask

  task automatic test_basic_drain();
    vec4_t a = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
    obs_t d;
    got4.delete(); want4.delete();
    step4(1'b1, a, 1'b1);
    for (int i = 0; i < L4; i++) begin
      step4(1'b0, zv, 1'b1);
      d = '{valid: 1'b1, busy: 1'b1, in_ready: (i == 3), last: (i == 3),
            index: 8'(i), data: a[i]};
      checks++;
      if (obs4 !== exp4 || obs4 !== d) begin
        errors++; $display("FAIL drain_elem%0d got %s want %s", i, fmt(obs4), fmt(d));
      end
    end
    step4(1'b0, zv, 1'b1);
    checks++;
    if (obs4.valid !== 1'b0 || obs4.in_ready !== 1'b1) begin
      errors++; $display("FAIL drain_idle got %s want valid=0 in_ready=1", fmt(obs4));
    end
  endtask

  task automatic test_backpressure();
    vec4_t a = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
    got4.delete(); want4.delete();
    step4(1'b1, a, 1'b1);
    step4(1'b0, zv, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step4(1'b1, rand_vec(), 1'b0);
      checks++;
      if (obs4 !== exp4 || obs4.data !== 16'h4000 || obs4.index !== 8'd1 ||
          obs4.valid !== 1'b1 || obs4.in_ready !== 1'b0) begin
        errors++; $display("FAIL stall%0d got %s want %s", i, fmt(obs4), fmt(exp4));
      end
    end
    for (int i = 0; i < 4; i++) begin
      step4(1'b0, zv, 1'b1);
      checks++;
      if (obs4 !== exp4) begin
        errors++; $display("FAIL bp_drain%0d got %s want %s", i, fmt(obs4), fmt(exp4));
      end
    end
    checks++;
    if (got4.size() != 4 || got4[0] !== 16'h3C00 || got4[1] !== 16'h4000 ||
        got4[2] !== 16'h4200 || got4[3] !== 16'h4400) begin
      errors++; $display("FAIL bp_stream got %0d elements %p want 3c00 4000 4200 4400", got4.size(), got4);
    end
  endtask

  task automatic test_back_to_back();
    vec4_t a = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
    vec4_t b = '{16'hBC00, 16'hC000, 16'hC200, 16'hC400};
    int vcount = 0;
    got4.delete(); want4.delete();
    step4(1'b1, a, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step4(1'b1, b, 1'b1);
      if (obs4.valid === 1'b1) vcount++;
      checks++;
      if (obs4 !== exp4 || obs4.in_ready !== (i == 3)) begin
        errors++; $display("FAIL b2b_first%0d got %s want %s", i, fmt(obs4), fmt(exp4));
      end
    end
    for (int i = 0; i < 4; i++) begin
      step4(1'b0, rand_vec(), 1'b1);
      if (obs4.valid === 1'b1) vcount++;
      checks++;
      if (obs4 !== exp4 || obs4.data !== b[i]) begin
        errors++; $display("FAIL b2b_second%0d got %s want %s", i, fmt(obs4), fmt(exp4));
      end
    end
    checks++;
    if (vcount != 8) begin
      errors++; $display("FAIL b2b_valid_run got %0d want 8", vcount);
    end
    checks++;
    if (got4.size() != 8 || got4[3] !== 16'h4400 || got4[4] !== 16'hBC00 || got4[7] !== 16'hC400) begin
      errors++; $display("FAIL b2b_stream got %p want a then b", got4);
    end
    step4(1'b0, zv, 1'b1);
  endtask

  task automatic test_idle_x();
    for (int i = 0; i < 2; i++) begin
      step4(1'b0, zv, 1'bx);
      checks++;
      if (obs4 !== exp4) begin
        errors++; $display("FAIL idle_x%0d got %s want %s", i, fmt(obs4), fmt(exp4));
      end
    end
  endtask

  task automatic test_reset_mid();
    vec4_t a = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
    vec4_t c = rand_vec();
    step4(1'b1, a, 1'b1);
    step4(1'b0, zv, 1'b1);
    step4(1'b0, zv, 1'b1);
    step4(1'b0, zv, 1'b0);
    checks++;
    if (obs4.index !== 8'd2 || obs4.valid !== 1'b1) begin
      errors++; $display("FAIL mid_pre got %s want valid=1 index=2", fmt(obs4));
    end
    reset = 1'b1;
    #1;
    obs4 = grab4();
    checks++;
    if (obs4 !== RESET_OBS) begin
      errors++; $display("FAIL mid_async got %s want %s", fmt(obs4), fmt(RESET_OBS));
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step4(1'b0, zv, 1'b1);
      checks++;
      if (obs4 !== exp4) begin
        errors++; $display("FAIL mid_after%0d got %s want %s", i, fmt(obs4), fmt(exp4));
      end
    end
    step4(1'b1, c, 1'b0);
    step4(1'b0, zv, 1'b1);
    checks++;
    if (obs4 !== exp4 || obs4.index !== 8'd0 || obs4.data !== c[0]) begin
      errors++; $display("FAIL mid_recapture got %s want %s", fmt(obs4), fmt(exp4));
    end
    for (int i = 0; i < 4; i++) step4(1'b0, zv, 1'b1);
  endtask

  task automatic test_length1();
    logic [DW-1:0] d;
    obs_t e;
    got1.delete(); want1.delete();
    for (int c = 0; c < 5; c++) begin
      d = (c < 3) ? DW'(c + 1) : '0;
      step(1'b0, zv, 1'b0, (c < 3), d, 1'b1);
      checks++;
      if (obs1 !== exp1) begin
        errors++; $display("FAIL len1_cyc%0d got %s want %s", c, fmt(obs1), fmt(exp1));
      end
      if (c >= 1 && c <= 3) begin
        e = '{valid: 1'b1, busy: 1'b1, in_ready: 1'b1, last: 1'b1, index: 8'd0, data: DW'(c)};
        checks++;
        if (obs1 !== e) begin
          errors++; $display("FAIL len1_elem%0d got %s want %s", c, fmt(obs1), fmt(e));
        end
      end
    end
  endtask

  task automatic test_random();
    got4.delete(); want4.delete(); got1.delete(); want1.delete();
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 1)), rand_vec(), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 3) != 0));
      checks++;
      if (obs4 !== exp4) begin
        errors++; $display("FAIL rand4_cyc%0d got %s want %s", c, fmt(obs4), fmt(exp4));
      end
      checks++;
      if (obs1 !== exp1) begin
        errors++; $display("FAIL rand1_cyc%0d got %s want %s", c, fmt(obs1), fmt(exp1));
      end
    end
    for (int c = 0; c < 6; c++) step(1'b0, zv, 1'b1, 1'b0, '0, 1'b1);
    checks++;
    if (got4 != want4) begin
      errors++; $display("FAIL rand4_stream got %0d elements want %0d", got4.size(), want4.size());
    end
    checks++;
    if (got1 != want1) begin
      errors++; $display("FAIL rand1_stream got %0d elements want %0d", got1.size(), want1.size());
    end
  endtask

  task automatic test_reset_idle();
    vec4_t a = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    step4(1'b1, a, 1'b1);
    for (int i = 0; i < 5; i++) step4(1'b0, zv, 1'b1);
    reset = 1'b1;
    #1;
    obs4 = grab4();
    checks++;
    if (obs4 !== RESET_OBS) begin
      errors++; $display("FAIL idle_reset_async got %s want %s", fmt(obs4), fmt(RESET_OBS));
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step4(1'b0, zv, 1'b1);
    checks++;
    if (obs4 !== RESET_OBS) begin
      errors++; $display("FAIL idle_reset_release got %s want %s", fmt(obs4), fmt(RESET_OBS));
    end
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_backpressure();
    test_back_to_back();
    test_idle_x();
    test_reset_mid();
    test_length1();
    test_random();
    test_reset_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_serializer.md
Name: vector_serializer

Overview:
- Output-side companion to the bias-add vector adder stage in the TTPU datapath.
- Accepts one complete LENGTH-element vector in parallel, such as the bias-added result row, through a valid/ready handshake.
- Streams that vector out one element per cycle, in index order, on a valid/ready stream for the result write-back / unified buffer path.
- Element contents are opaque bit patterns (FP16 by default); no arithmetic is done on data.

Parameters:
- DATA_WIDTH, 16, bit width of one vector element.
- LENGTH, 16, number of elements per vector; legal range 1..256.
- IDX_WIDTH, (LENGTH>1 ? $clog2(LENGTH) : 1), width of the element index; derived, not overridden.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- in_vec  input  DATA_WIDTH x [0:LENGTH-1]  parallel input vector (unpacked array, same form as the vector adder Out).
- in_valid  input  1  in_vec is valid this cycle.
- in_ready  output  1  block can capture in_vec this cycle.
- out_data  output  DATA_WIDTH  current element.
- out_index  output  IDX_WIDTH  index of out_data within its vector.
- out_last  output  1  out_data is element LENGTH-1.
- out_valid  output  1  out_data/out_index/out_last are valid.
- out_ready  input  1  downstream accepts the element this cycle.
- busy  output  1  a vector is held and not fully drained.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-high.
- State machine: two states, IDLE and SEND.
- Registered state: state, idx[IDX_WIDTH-1:0], buf[0:LENGTH-1].
- Reset (asynchronous, active-high):
  - state=IDLE, idx=0, every buf entry=0.
  - out_valid=0, out_last=0, out_index=0, out_data=0, busy=0, in_ready=1 (combinational from state).
- Transfer definitions:
  - Input capture = in_valid & in_ready at a rising edge.
  - Output transfer = out_valid & out_ready at a rising edge.
- Combinational outputs:
  - out_valid = busy = (state==SEND).
  - out_data = buf[idx]; out_index = idx.
  - out_last = (state==SEND) & (idx==LENGTH-1).
  - in_ready = (state==IDLE) | (state==SEND & out_ready & idx==LENGTH-1).
- IDLE:
  - On capture: buf<=in_vec (all LENGTH entries), idx<=0, go to SEND.
  - Without capture: hold.
- SEND, output transfer with idx<LENGTH-1: idx<=idx+1.
- SEND, output transfer with idx==LENGTH-1:
  - If in_valid is also high, capture the new vector (buf<=in_vec, idx<=0) and stay in SEND. There is no bubble between vectors.
  - Otherwise idx<=0, go to IDLE.
- SEND without output transfer:
  - Hold everything.
  - out_data, out_index and out_last stay stable while out_valid=1 and out_ready=0. in_vec is ignored.
- Latency:
  - Element 0 is on out_data with out_valid=1 in the cycle after capture.
  - With out_ready held high, a full vector drains in LENGTH cycles; sustained throughput is one vector per LENGTH cycles.
- in_ready has a combinational dependency on out_ready. in_valid must not depend combinationally on in_ready.
- in_vec needs to be stable only in the capture cycle. Later changes do not affect buf.
- LENGTH=1:
  - idx stays 0; out_last=1 whenever out_valid=1.
  - Each output transfer frees the block, so a vector can be accepted every cycle.
- idx never exceeds LENGTH-1; no wrap past LENGTH-1 for non-power-of-two LENGTH.
- Reset mid-vector: remaining elements are dropped. Outputs reach their reset values asynchronously, and no partial vector is re-emitted after reset release.
- in_valid with in_ready=0: no capture. Upstream must hold in_vec/in_valid until accepted.
- X on out_ready while out_valid=0 has no effect.

Test Plan:
- Reset then idle: assert reset mid-sim with in_valid=0 -> in_ready=1, out_valid=0, busy=0, out_index=0, out_data=16'h0000 immediately (asynchronously) and after release.
- Basic drain, LENGTH=4, out_ready=1: capture {16'h3C00,16'h4000,16'h4200,16'h4400} at edge k -> out_data 3C00/4000/4200/4400 with out_index 0..3 on cycles k+1..k+4, out_last=1 only with 4400; in_ready=0 during k+1..k+3; IDLE after k+4.
- Backpressure: same vector, out_ready low for 3 cycles while showing index 1 -> out_data=16'h4000, out_index=1 held stable; all 4 elements delivered exactly once, in order.
- Back-to-back: second vector {16'hBC00,16'hC000,16'hC200,16'hC400} with in_valid high from cycle k+1 -> in_ready=1 only in cycle k+4; 8 consecutive out_valid cycles; BC00 directly follows 4400; in_vec changes after capture do not alter the output.
- Reset mid-vector: assert reset while out_index=2 -> out_valid drops asynchronously; after release no element of that vector appears, and a new capture starts at index 0.
- LENGTH=1 build: in_valid=1 and out_ready=1 every cycle with data 16'h0001, 16'h0002, 16'h0003 -> one element per cycle, each with out_last=1, out_index=0, in order with 1-cycle latency.
